// File: rtl/block_serializer_pkg.sv
// block_serializer_pkg: shared widths and read FSM encoding for the block serializer.
package block_serializer_pkg;
   localparam int WORD_W = 64;
   localparam int NUM_WORDS = 40;
   localparam int IDX_W = 6;
   localparam int BLK_W = NUM_WORDS * WORD_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/block_serializer_if.sv
// block_serializer_if: block-in and word-out handshakes of the serializer.
interface block_serializer_if;
   import block_serializer_pkg::*;
   logic blk_valid;
   logic blk_ready;
   logic [BLK_W-1:0] blk_data;
   logic out_valid;
   logic out_ready;
   logic [WORD_W-1:0] out_data;
   logic [IDX_W-1:0] out_idx;
   logic out_last;
   modport master (output blk_valid, blk_data, out_ready,
                   input blk_ready, out_valid, out_data, out_idx, out_last);
   modport slave (input blk_valid, blk_data, out_ready,
                  output blk_ready, out_valid, out_data, out_idx, out_last);
endinterface

// File: rtl/block_word_mux.sv
// block_word_mux: picks one word out of a stored block.
module block_word_mux
   import block_serializer_pkg::*;
(
   input  logic [BLK_W-1:0]  blk_i,
   input  logic [IDX_W-1:0]  sel_i,
   output logic [WORD_W-1:0] word_o
);
   assign word_o = blk_i[sel_i * WORD_W +: WORD_W];
endmodule

// File: rtl/block_serializer.sv
// block_serializer: two-slot ping-pong block store streamed out one word per beat, MSB word first.
module block_serializer
   import block_serializer_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   block_serializer_if.slave bus,
   output logic            busy_o
);
   state_e state_q, state_d;
   logic [BLK_W-1:0] slot_q [2];
   logic wr_ptr_q, rd_ptr_q, sel_slot;
   logic [1:0] occ_q, occ_d;
   logic valid_q, valid_d, last_q, last_d;
   logic acc, beat, rel;
   logic [WORD_W-1:0] data_q, data_d, word;
   logic [IDX_W-1:0] idx_q, idx_d, sel_word;

   assign acc = bus.blk_valid & bus.blk_ready;
   assign beat = valid_q & bus.out_ready;
   assign rel = beat & last_q;
   assign bus.blk_ready = occ_q != 2'd2;
   assign occ_d = occ_q + {1'b0, acc} - {1'b0, rel};
   assign busy_o = (occ_q != 2'd0) | valid_q;
   assign bus.out_valid = valid_q;
   assign bus.out_data = data_q;
   assign bus.out_idx = idx_q;
   assign bus.out_last = last_q;
   assign sel_word = LAST_IDX - idx_d;

   block_word_mux u_mux (.blk_i(slot_q[sel_slot]), .sel_i(sel_word), .word_o(word));

   // The mux always reads the word that the next-state index points at, so stalls re-load the same word.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      idx_d = idx_q;
      sel_slot = rd_ptr_q;
      if (state_q == IDLE) begin
         state_d = (occ_q != 2'd0) ? SEND : IDLE;
         valid_d = occ_q != 2'd0;
         idx_d = '0;
      end else if (rel) begin
         idx_d = '0;
         sel_slot = ~rd_ptr_q;
         state_d = (occ_q == 2'd2) ? SEND : IDLE;
         valid_d = occ_q == 2'd2;
      end else if (beat) begin
         idx_d = idx_q + 1'b1;
      end
      last_d = valid_d & (idx_d == LAST_IDX);
      data_d = valid_d ? word : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         occ_q <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         valid_q <= 1'b0;
         data_q <= '0;
         idx_q <= '0;
         last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q <= occ_d;
         wr_ptr_q <= wr_ptr_q ^ acc;
         rd_ptr_q <= rd_ptr_q ^ rel;
         valid_q <= valid_d;
         data_q <= data_d;
         idx_q <= idx_d;
         last_q <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc) slot_q[wr_ptr_q] <= bus.blk_data;
   end
endmodule

// File: tb/tb_block_serializer.sv
// tb_block_serializer: table vectors, directed corner sequences and random traffic against a queue model.
module tb_block_serializer;
   import block_serializer_pkg::*;

   typedef struct {
      logic [WORD_W-1:0] d;
      logic [IDX_W-1:0]  idx;
      logic              last;
   } beat_t;

   typedef struct {
      logic [63:0] base;
      logic [63:0] step;
      logic [63:0] exp_first;
      logic [63:0] exp_last;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   block_serializer_if bus ();

   block_serializer dut (.clk(clk), .rst(rst), .bus(bus), .busy_o(busy));

   always #5 clk = ~clk;

   beat_t exp_q[$];
   int m_occ = 0;
   int n_cmp = 0;
   int n_fail = 0;
   int beat_cnt = 0;
   logic stall_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: a block is just 40 queued beats in MSB-first order; occupancy counts unfinished blocks.
   always @(negedge clk) begin : mon
      beat_t b;
      bit acc;
      if (rst) begin
         exp_q.delete();
         m_occ = 0;
         stall_prev = 1'b0;
      end else begin
         chk("blk_ready", bus.blk_ready, 64'(m_occ != 2));
         chk("busy", busy, 64'(m_occ != 0));
         if (stall_prev) chk("stall_valid", bus.out_valid, 1);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", bus.out_valid, 0);
            else begin
               chk("out_data", bus.out_data, exp_q[0].d);
               chk("out_idx", bus.out_idx, exp_q[0].idx);
               chk("out_last", bus.out_last, exp_q[0].last);
            end
         end
         acc = bus.blk_valid && (m_occ != 2);
         if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            beat_cnt++;
            if (b.last) m_occ--;
         end
         if (acc) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
               b.d = bus.blk_data[(NUM_WORDS - 1 - k) * WORD_W +: WORD_W];
               b.idx = IDX_W'(k);
               b.last = (k == NUM_WORDS - 1);
               exp_q.push_back(b);
            end
            m_occ++;
         end
         stall_prev = bus.out_valid & ~bus.out_ready;
      end
   end

   function automatic logic [BLK_W-1:0] rand_block();
      logic [BLK_W-1:0] r;
      for (int k = 0; k < NUM_WORDS; k++) r[k * WORD_W +: WORD_W] = {$urandom, $urandom};
      return r;
   endfunction

   task automatic send_block(input logic [BLK_W-1:0] b);
      bit done = 0;
      bus.blk_valid = 1'b1;
      bus.blk_data = b;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         done = bus.blk_ready;
         @(posedge clk);
         #1;
      end
      bus.blk_valid = 1'b0;
      if (!done) chk("accept_timeout", bus.blk_ready, 1);
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 600 && (exp_q.size() != 0 || bus.out_valid); t++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[4];
      logic [BLK_W-1:0] a, b, c;
      int b0;
      vt[0] = '{64'd0, 64'd1, 64'd39, 64'd0};
      vt[1] = '{64'hFFFF_FFFF_FFFF_FF00, 64'd1, 64'hFFFF_FFFF_FFFF_FF27, 64'hFFFF_FFFF_FFFF_FF00};
      vt[2] = '{64'h1000, 64'h100, 64'h3700, 64'h1000};
      vt[3] = '{64'h8000_0000_0000_0000, 64'h1_0000_0000, 64'h8000_0027_0000_0000, 64'h8000_0000_0000_0000};
      bus.blk_valid = 1'b0;
      bus.blk_data = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_idx", bus.out_idx, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_blk_ready", bus.blk_ready, 1);
      @(posedge clk);
      #1;

      // single blocks: latency, consecutive beats, first/last words
      for (int v = 0; v < 4; v++) begin
         drain();
         for (int k = 0; k < NUM_WORDS; k++) a[k * WORD_W +: WORD_W] = vt[v].base + 64'(k) * vt[v].step;
         send_block(a);
         @(negedge clk);
         chk("lat_edge_n", bus.out_valid, 0);
         @(negedge clk);
         chk("lat_edge_n1", bus.out_valid, 1);
         chk("first_data", bus.out_data, vt[v].exp_first);
         chk("first_idx", bus.out_idx, 0);
         for (int i = 1; i < NUM_WORDS; i++) begin
            @(negedge clk);
            chk("run_valid", bus.out_valid, 1);
            chk("run_idx", bus.out_idx, 64'(i));
            if (i == NUM_WORDS - 1) begin
               chk("final_data", bus.out_data, vt[v].exp_last);
               chk("final_last", bus.out_last, 1);
            end else chk("early_last", bus.out_last, 0);
         end
         @(negedge clk);
         chk("after_valid", bus.out_valid, 0);
         @(posedge clk);
         #1;
      end

      // three blocks back to back: 120 beats with no gap
      drain();
      fork
         begin
            send_block(rand_block());
            send_block(rand_block());
            send_block(rand_block());
         end
         begin
            for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
            for (int i = 0; i < 3 * NUM_WORDS; i++) begin
               chk("t2_nogap", bus.out_valid, 1);
               @(negedge clk);
            end
            chk("t2_end", bus.out_valid, 0);
         end
      join
      @(posedge clk);
      #1;

      // alternating out_ready: exactly 40 beats
      drain();
      bus.out_ready = 1'b0;
      b0 = beat_cnt;
      send_block(rand_block());
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
         bus.out_ready = ~bus.out_ready;
         @(posedge clk);
         #1;
      end
      chk("t3_beats", beat_cnt - b0, NUM_WORDS);

      // full store with a block waiting on the first slot's release
      drain();
      bus.out_ready = 1'b0;
      send_block(rand_block());
      send_block(rand_block());
      bus.out_ready = 1'b1;
      send_block(rand_block());
      drain();

      // reset mid-stream with a queued block
      send_block(rand_block());
      send_block(rand_block());
      for (int t = 0; t < 200 && !(bus.out_valid && bus.out_idx == 6'd16); t++) @(negedge clk);
      @(posedge clk);
      #1;
      chk("t5_idx17", bus.out_idx, 17);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_valid", bus.out_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_ready", bus.blk_ready, 1);
      c = rand_block();
      send_block(c);
      @(negedge clk);
      @(negedge clk);
      chk("t5_fresh_idx", bus.out_idx, 0);
      chk("t5_fresh_data", bus.out_data, c[(NUM_WORDS - 1) * WORD_W +: WORD_W]);
      drain();

      // blk_valid while full and stalled is ignored
      bus.out_ready = 1'b0;
      send_block(rand_block());
      send_block(rand_block());
      for (int i = 0; i < 5; i++) begin
         bus.blk_valid = 1'b1;
         bus.blk_data = rand_block();
         @(negedge clk);
         chk("t6_ready", bus.blk_ready, 0);
         @(posedge clk);
         #1;
      end
      bus.blk_valid = 1'b0;
      drain();

      // random traffic
      for (int t = 0; t < 2500; t++) begin
         bus.out_ready = $urandom_range(0, 3) != 0;
         bus.blk_valid = $urandom_range(0, 2) == 0;
         if (bus.blk_valid) bus.blk_data = rand_block();
         @(posedge clk);
         #1;
      end
      bus.blk_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
